// File: rtl/gray_to_binary_pkg.sv
// gray_to_binary_pkg: shared helpers for the Gray-to-binary converter
package gray_to_binary_pkg;
    localparam int MAX_WIDTH = 32;

    // true when more than one bit is set: clearing the lowest set bit leaves something behind
    function automatic logic multi_bit_diff(input logic [MAX_WIDTH-1:0] d);
        return (d & (d - 32'd1)) != '0;
    endfunction
endpackage

// File: rtl/gray2bin_comb.sv
// gray2bin_comb: combinational Gray-to-binary prefix XOR from the MSB
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign binary[b] = ^gray[WIDTH-1:b];
    end
endmodule

// File: rtl/gray_to_binary.sv
// gray_to_binary: registered Gray-to-binary converter with valid and step-error flag
module gray_to_binary
    import gray_to_binary_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic [WIDTH-1:0] binary,
    output logic             step_err
);
    logic [WIDTH-1:0] bin_c;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;

    gray2bin_comb #(.WIDTH(WIDTH)) u_conv (
        .gray   (gray),
        .binary (bin_c)
    );

    // every path gates gray through in_valid so idle-cycle X never reaches state
    always_comb begin
        valid_d     = in_valid;
        binary_d    = in_valid ? bin_c : binary_q;
        err_d       = in_valid ? (have_prev_q && multi_bit_diff(MAX_WIDTH'(gray ^ prev_q))) : err_q;
        prev_d      = in_valid ? gray : prev_q;
        have_prev_d = have_prev_q || in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            binary_q    <= '0;
            err_q       <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            binary_q    <= binary_d;
            err_q       <= err_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign out_valid = valid_q;
    assign binary    = binary_q;
    assign step_err  = err_q;
endmodule

// File: tb/tb_gray_to_binary.sv
// tb_gray_to_binary: directed checks of the Gray-to-binary converter at WIDTH 4 and 8
module tb_gray_to_binary;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] gray = '0;
    logic       out_valid;
    logic [3:0] binary;
    logic       step_err;
    logic       v8 = 1'b0;
    logic [7:0] g8 = '0;
    logic       ov8;
    logic [7:0] b8;
    logic       e8;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    gray_to_binary #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .gray      (gray),
        .out_valid (out_valid),
        .binary    (binary),
        .step_err  (step_err)
    );

    gray_to_binary #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .gray      (g8),
        .out_valid (ov8),
        .binary    (b8),
        .step_err  (e8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] g);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        gray     = g;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input string tag, input logic r, input logic v, input logic [3:0] g,
                         input logic ov, input logic [3:0] b, input logic e);
        drive(r, v, g);
        check({tag, ".ov"}, 32'(out_valid), 32'(ov));
        check({tag, ".bin"}, 32'(binary), 32'(b));
        check({tag, ".err"}, 32'(step_err), 32'(e));
    endtask

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [3:0] seq_g [12] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110};

    initial begin
        step4("rst0", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        step4("rst1", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 12; i++)
            step4($sformatf("seq%0d", i), 1'b1, 1'b1, seq_g[i], 1'b1, 4'(i), 1'b0);
        // 1110 -> 0000 is three bits apart
        step4("jump_a", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1);
        step4("jump_b", 1'b1, 1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1);
        step4("jump_c", 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0011, 1'b0);
        step4("gap_a", 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++)
            step4($sformatf("idle%0d", i), 1'b1, 1'b0, 4'bxxxx, 1'b0, 4'b0100, 1'b0);
        step4("gap_b", 1'b1, 1'b1, 4'b0111, 1'b1, 4'b0101, 1'b0);
        step4("repeat", 1'b1, 1'b1, 4'b0111, 1'b1, 4'b0101, 1'b0);
        step4("mid_a", 1'b1, 1'b1, 4'b0101, 1'b1, 4'b0110, 1'b0);
        step4("mid_rst", 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        step4("mid_b", 1'b1, 1'b1, 4'b1010, 1'b1, 4'b1100, 1'b0);
        step4("wrap_a", 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1111, 1'b0);
        step4("wrap_b", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
        step4("xidle", 1'b1, 1'b0, 4'bxxxx, 1'b0, 4'b0000, 1'b0);
        step4("after_x", 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0);
        drive(1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        v8 = 1'b1;
        g8 = 8'b1000_0000;
        @(posedge clk);
        #1;
        check("w8_msb.ov", 32'(ov8), 32'd1);
        check("w8_msb.bin", 32'(b8), 32'hff);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g;
            g = 8'($urandom);
            @(negedge clk);
            g8 = g;
            @(posedge clk);
            #1;
            check($sformatf("w8_rand%0d", i), 32'(b8), 32'(g2b8(g)));
        end
        @(negedge clk);
        v8 = 1'b0;
        @(posedge clk);
        #1;
        check("w8_idle.ov", 32'(ov8), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gray_to_binary.md
Name: gray_to_binary

Overview:
- Registered, parameterised Gray-code to natural-binary converter with a valid qualifier.
- Also flags adjacent valid samples that break the single-bit Gray-step property.
- Sits after Gray-coded sources such as encoders, async-FIFO pointers and position sensors. It presents binary values to downstream arithmetic.

Parameters:
- WIDTH, 4, bit width of the gray input and binary output; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  gray is sampled on this clock edge when high.
- gray  input  WIDTH  Gray-coded value.
- out_valid  output  1  binary and step_err are valid this cycle.
- binary  output  WIDTH  converted value, registered.
- step_err  output  1  high with out_valid when the current sample differs from the previous valid sample in more than one bit.

Behaviour:
- Conversion rule: binary[WIDTH-1] = gray[WIDTH-1]; binary[i] = binary[i+1] XOR gray[i], for i = WIDTH-2 down to 0. This is a prefix XOR from the MSB.
- Reset: on a clk edge with rst_n=0, clear out_valid=0, binary=0, step_err=0, the previous-sample register and the have_prev flag. Reset overrides in_valid in the same cycle.
- Latency: exactly 1 cycle. in_valid=1 at edge N gives out_valid=1 with the result after edge N.
- out_valid equals in_valid delayed one cycle. There is no backpressure and full throughput: one conversion per cycle.
- When in_valid=0, out_valid drops to 0. binary and step_err hold their last values; consumers ignore them.
- Step check:
  - Compute the Hamming distance between gray and the stored previous valid gray.
  - step_err=1 iff have_prev=1 and distance >= 2.
  - Distance 0 (repeated value) and distance 1 are legal.
  - The first valid sample after reset never flags.
  - Wrap-around (e.g. 1000 -> 0000 for WIDTH=4) has distance 1, so it is legal.
- Every valid sample updates the previous-sample register, including erroneous ones, and sets have_prev=1.
- Invalid cycles do not update the previous-sample register. Gaps between valid samples are transparent to the step check.
- Reset mid-stream: clears have_prev, so the next valid sample does not flag.
- X/unknown inputs while in_valid=0 must not affect any state.

Decomposition:
- Sub-module gray2bin_comb: purely combinational, parameter WIDTH, port gray in and binary out; implements the prefix XOR.
- The top level instantiates gray2bin_comb and owns the registers, the valid pipeline and the step checker.
- No shared package is required. The Hamming-distance check (popcount >= 2 of an XOR) may be a local function in the top level.

Test Plan:
- Reset behaviour: assert rst_n=0 for 2 cycles with in_valid=1 and gray=4'b1111 -> out_valid=0, binary=0, step_err=0 throughout.
- Full sequence, WIDTH=4, one sample per cycle:
  - Inputs: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110.
  - Expected binary, one cycle later: 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000, 1001, 1010, 1011.
  - step_err stays 0 and out_valid stays 1.
- Step error: valid 0000 then valid 0011 -> second result binary=0010 with step_err=1. A following valid 0010 gives binary=0011 with step_err=0.
- Gaps and repeats:
  - 0110, then 3 idle cycles, then 0111 -> out_valid pulses only on the two result cycles; step_err=0 on both.
  - Repeated 0111 -> step_err=0.
- Reset mid-stream: valid 0101, then a rst_n pulse, then valid 1010 -> 1010 result is binary=1100 with step_err=0 (no previous sample).
- Wrap and width: for WIDTH=4, 1000 then 0000 -> binary 1111 then 0000, step_err=0. Re-run conversion of random values with WIDTH=8 against the prefix-XOR model; 8'b1000_0000 -> 8'b1111_1111.
